// File: rtl/frcounter_checker.sv
// Consumer-side checker for a free-running counter interface.
// Locks onto a consistent incrementing sequence, then flags every sample
// whose value or terminal-count flag departs from the expected count.
// Ports:
//   clk_in, rst_in        clock, asynchronous active-high reset
//   en_in                 sample enable
//   data_in, tc_in        counter value and terminal-count flag under check
//   clear_in              synchronous clear of fail_out / err_count_out
//   locked_out            high while locked
//   err_out               one-cycle pulse per mismatching sample
//   fail_out              sticky error flag
//   err_count_out         saturating error count
//   expected_out          next expected value (meaningful while locked)
module frcounter_checker #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned LOCK_CYCLES   = 4,
  parameter int unsigned ERR_CNT_WIDTH = 8
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     en_in,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     tc_in,
  input  logic                     clear_in,
  output logic                     locked_out,
  output logic                     err_out,
  output logic                     fail_out,
  output logic [ERR_CNT_WIDTH-1:0] err_count_out,
  output logic [WIDTH-1:0]         expected_out
);

  localparam int unsigned RUN_W = 4;
  localparam logic [WIDTH-1:0]         MAX_VAL = {WIDTH{1'b1}};
  localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX = {ERR_CNT_WIDTH{1'b1}};

  typedef enum logic [0:0] {
    ST_ACQUIRE = 1'b0,
    ST_LOCKED  = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [WIDTH-1:0]         prev_q, prev_d;
  logic [RUN_W-1:0]         run_cnt_q, run_cnt_d;
  logic [WIDTH-1:0]         expected_q, expected_d;
  logic                     err_q, err_d;
  logic                     fail_q, fail_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  logic consistent_c;
  logic successor_c;
  logic match_c;
  logic flag_c;

  // A sample is consistent when tc marks exactly the all-ones value.
  assign consistent_c = (tc_in == (data_in == MAX_VAL));
  assign successor_c  = (data_in == WIDTH'(prev_q + 1'b1));
  assign match_c      = (data_in == expected_q) && (tc_in == (expected_q == MAX_VAL));

  // Next-state, lock tracking and error bookkeeping.
  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    run_cnt_d  = run_cnt_q;
    expected_d = expected_q;
    err_d      = 1'b0;
    fail_d     = fail_q;
    err_cnt_d  = err_cnt_q;
    flag_c     = 1'b0;

    case (state_q)
      ST_ACQUIRE: begin
        if (en_in) begin
          prev_d = data_in;
          if (!consistent_c) begin
            run_cnt_d = '0;
          end else if ((run_cnt_q != '0) && successor_c) begin
            run_cnt_d = RUN_W'(run_cnt_q + 1'b1);
          end else begin
            run_cnt_d = RUN_W'(1);
          end
          if (run_cnt_d == RUN_W'(LOCK_CYCLES)) begin
            state_d    = ST_LOCKED;
            expected_d = WIDTH'(data_in + 1'b1);
            run_cnt_d  = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (en_in) begin
          if (match_c) begin
            expected_d = WIDTH'(expected_q + 1'b1);
          end else begin
            flag_c    = 1'b1;
            state_d   = ST_ACQUIRE;
            prev_d    = data_in;
            run_cnt_d = consistent_c ? RUN_W'(1) : '0;
          end
        end
      end
      default: state_d = ST_ACQUIRE;
    endcase

    // Clear first so a coincident error still registers.
    if (clear_in) begin
      fail_d    = 1'b0;
      err_cnt_d = '0;
    end
    if (flag_c) begin
      err_d  = 1'b1;
      fail_d = 1'b1;
      if (err_cnt_d != CNT_MAX) begin
        err_cnt_d = ERR_CNT_WIDTH'(err_cnt_d + 1'b1);
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= ST_ACQUIRE;
      prev_q     <= '0;
      run_cnt_q  <= '0;
      expected_q <= '0;
      err_q      <= 1'b0;
      fail_q     <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      run_cnt_q  <= run_cnt_d;
      expected_q <= expected_d;
      err_q      <= err_d;
      fail_q     <= fail_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign locked_out    = (state_q == ST_LOCKED);
  assign err_out       = err_q;
  assign fail_out      = fail_q;
  assign err_count_out = err_cnt_q;
  assign expected_out  = expected_q;

endmodule

// File: tb/tb_frcounter_checker.sv
module tb_frcounter_checker;

  localparam int MAXV = 15;
  localparam int LOCKN = 4;
  localparam int CNTMAX = 255;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       en_in = 1'b0;
  logic [3:0] data_in = '0;
  logic       tc_in = 1'b0;
  logic       clear_in = 1'b0;
  logic       locked_out;
  logic       err_out;
  logic       fail_out;
  logic [7:0] err_count_out;
  logic [3:0] expected_out;

  frcounter_checker #(.WIDTH(4), .LOCK_CYCLES(4), .ERR_CNT_WIDTH(8)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .en_in         (en_in),
    .data_in       (data_in),
    .tc_in         (tc_in),
    .clear_in      (clear_in),
    .locked_out    (locked_out),
    .err_out       (err_out),
    .fail_out      (fail_out),
    .err_count_out (err_count_out),
    .expected_out  (expected_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int locked;
    int err;
    int fail;
    int cnt;
    int expv;
  } resp_t;

  resp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model state, kept as plain integers.
  int m_locked, m_exp, m_run, m_prev, m_fail, m_cnt, m_err;
  int cur;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_exp = 0; m_run = 0; m_prev = 0;
    m_fail = 0; m_cnt = 0; m_err = 0;
  endtask

  task automatic model_step(input int en, input int d, input int tc, input int clr);
    int cons;
    cons = (tc == ((d == MAXV) ? 1 : 0)) ? 1 : 0;
    m_err = 0;
    if (en != 0) begin
      if (m_locked == 0) begin
        if (cons == 0) m_run = 0;
        else if (m_run > 0 && d == (m_prev + 1) % 16) m_run = m_run + 1;
        else m_run = 1;
        m_prev = d;
        if (m_run == LOCKN) begin
          m_locked = 1;
          m_exp = (d + 1) % 16;
          m_run = 0;
        end
      end else if (d == m_exp && tc == ((m_exp == MAXV) ? 1 : 0)) begin
        m_exp = (m_exp + 1) % 16;
      end else begin
        m_err = 1;
        m_locked = 0;
        m_prev = d;
        m_run = cons;
      end
    end
    if (clr != 0) begin
      m_fail = 0;
      m_cnt = 0;
    end
    if (m_err != 0) begin
      m_fail = 1;
      if (m_cnt < CNTMAX) m_cnt = m_cnt + 1;
    end
  endtask

  // Drive one sample and record what the DUT must show after the next edge.
  task automatic drive(input int en, input int d, input int tc, input int clr);
    resp_t r;
    @(negedge clk_in);
    en_in = (en != 0);
    data_in = 4'(d);
    tc_in = (tc != 0);
    clear_in = (clr != 0);
    model_step(en, d, tc, clr);
    r.locked = m_locked; r.err = m_err; r.fail = m_fail;
    r.cnt = m_cnt; r.expv = m_exp;
    sb.push_back(r);
  endtask

  task automatic good(input int d);
    drive(1, d % 16, ((d % 16) == MAXV) ? 1 : 0, 0);
  endtask

  task automatic lock_from(input int start);
    for (int i = 0; i < LOCKN; i++) good(start + i);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    en_in = 1'b0;
    clear_in = 1'b0;
    rst_in = 1'b1;
    #1;
    chk("rst_locked", int'(locked_out), 0);
    chk("rst_err", int'(err_out), 0);
    chk("rst_fail", int'(fail_out), 0);
    chk("rst_cnt", int'(err_count_out), 0);
    chk("rst_expected", int'(expected_out), 0);
    model_reset();
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  // Monitor: every registered response is compared one edge after its sample.
  always @(posedge clk_in) begin
    resp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("locked_out", int'(locked_out), e.locked);
      chk("err_out", int'(err_out), e.err);
      chk("fail_out", int'(fail_out), e.fail);
      chk("err_count_out", int'(err_count_out), e.cnt);
      if (e.locked != 0) chk("expected_out", int'(expected_out), e.expv);
    end
  end

  initial begin
    #200000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    #12;
    do_reset();

    // Basic lock, then run through wrap.
    lock_from(0);
    for (int v = 4; v <= 17; v++) good(v);
    // Expected now 2; advance to 5, then a data error and relock.
    good(2); good(3); good(4);
    drive(1, 7, 0, 0);
    good(8); good(9); good(10);
    // tc missing on 15: error.
    drive(1, 15, 0, 0);
    lock_from(0);
    for (int v = 4; v <= 8; v++) good(v);
    // tc asserted on 9 while expecting 9: error.
    drive(1, 9, 1, 0);

    // Enable gap with garbage, then resume at expected value.
    lock_from(3);
    for (int i = 0; i < 10; i++) drive(0, $urandom_range(0, 15), $urandom_range(0, 1), 0);
    good(7); good(8);

    // Asynchronous reset mid-stream, then relock needs fresh samples.
    good(9);
    do_reset();
    good(10); good(11); good(12);
    good(13);
    good(14);

    // Saturation: 300 errors.
    for (int i = 0; i < 300; i++) begin
      lock_from(i);
      drive(1, (i + 6) % 16, ((i + 6) % 16 == MAXV) ? 0 : 1, 0);
    end
    // Clear coincident with an error, then clear alone.
    lock_from(1);
    drive(1, 9, 0, 1);
    drive(0, 0, 0, 1);

    // Randomized phase.
    cur = 0;
    for (int i = 0; i < 1500; i++) begin
      int en, r, d, tc, clr;
      en = ($urandom_range(0, 9) != 0) ? 1 : 0;
      r = $urandom_range(0, 24);
      clr = ($urandom_range(0, 59) == 0) ? 1 : 0;
      if (r == 0) begin
        d = $urandom_range(0, 15);
        tc = $urandom_range(0, 1);
      end else if (r == 1) begin
        d = cur;
        tc = (cur == MAXV) ? 0 : 1;
      end else begin
        d = cur;
        tc = (cur == MAXV) ? 1 : 0;
      end
      drive(en, d, tc, clr);
      if (en != 0) cur = (d + 1) % 16;
    end

    @(negedge clk_in);
    en_in = 1'b0;
    @(negedge clk_in);
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frcounter_checker.md
Name: frcounter_checker

Overview:
- Synthesizable monitor for the free-running counter's output interface (`data_out`/`tc_out`). It sits on the consumer side of that interface.
- Acquires lock on a valid incrementing sequence, then checks every sampled value and terminal-count flag against its own expected count.
- Reports per-sample errors, a sticky fail flag and a saturating error count. Used for on-board self-test and as a reusable bench checker.

Parameters:
- WIDTH, 4, width of the monitored count; the count wraps at 2^WIDTH-1.
- LOCK_CYCLES, 4, number of consecutive consistent samples needed to enter LOCKED (range 2..15).
- ERR_CNT_WIDTH, 8, width of the saturating error counter.

Ports:
- clk_in  input  1  system clock; all logic samples on the rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- en_in  input  1  sample enable; data_in and tc_in are evaluated only when en_in=1.
- data_in  input  WIDTH  counter value under check.
- tc_in  input  1  terminal-count flag under check.
- clear_in  input  1  synchronous clear of fail_out and err_count_out.
- locked_out  output  1  high while in LOCKED.
- err_out  output  1  one-cycle pulse per mismatching sample.
- fail_out  output  1  sticky; set by any error.
- err_count_out  output  ERR_CNT_WIDTH  number of errors, saturating at all-ones.
- expected_out  output  WIDTH  next expected value (valid while locked).

Behaviour:
- Interface decision: one clock, clk_in. Reset rst_in is asynchronous and active-high.
- Reset state: ACQUIRE. All outputs are 0, and internal prev, run_cnt and expected are 0. Reset takes effect immediately at any point in operation and discards lock.
- All outputs are registered. Responses appear one cycle after the sampling edge.
- Consistency rule for a sample: tc_in == (data_in == 2^WIDTH-1). A sample that breaks this rule is "tc-inconsistent".
- State ACQUIRE (the en_in=1 sample updates the state as follows; no errors are flagged in this state):
  - Sample is consistent, run_cnt>0 and data_in == prev+1 mod 2^WIDTH: run_cnt++.
  - Sample is consistent but not a valid successor: run_cnt=1.
  - Sample is tc-inconsistent: run_cnt=0.
  - On every sample, prev=data_in.
  - When run_cnt reaches LOCK_CYCLES: go to LOCKED, expected=data_in+1 mod 2^WIDTH, locked_out=1 on the next cycle.
- State LOCKED (en_in=1 sample):
  - Match condition: data_in==expected AND tc_in==(expected==2^WIDTH-1).
  - Match: expected=expected+1 (wrapping from 2^WIDTH-1 to 0). Stay in LOCKED.
  - Mismatch (data, tc or both counts as one error):
    - err_out=1 for exactly one cycle; fail_out=1; err_count_out increments unless saturated.
    - Go to ACQUIRE with prev=data_in and run_cnt=1 if the sample is consistent, else 0. locked_out=0.
- en_in=0: no state change and no error. The gap length is irrelevant; checking resumes with the same expected value.
- clear_in=1: fail_out=0 and err_count_out=0. If an error is flagged in the same cycle, the error is applied after the clear: fail_out=1 and err_count_out=1. clear_in does not affect lock state.
- expected_out holds the last expected value while in ACQUIRE.

Test Plan:
- Reset, then feed 0,1,2,3 with en_in=1 and tc=0 → locked_out=1 one cycle after the 4th sample, expected_out=4, err_out never asserted.
- While locked, feed 13,14,15(tc=1),0,1 → no err_out, expected_out goes 14,15,0,1,2, fail_out stays 0.
- While locked with expected=5, feed 7 → err_out pulses for 1 cycle, fail_out=1, err_count_out=1, locked_out=0. Then feed 8,9,10 → relock (run_cnt 1→4), locked_out=1.
- While locked, feed 15 with tc_in=0 → error, err_count_out increments. Also feed 9 with tc_in=1 while expecting 9 → error.
- Lock, then set en_in=0 for 10 cycles with garbage on data_in, then resume at the expected value → no error. Separately, assert rst_in mid-stream → all outputs read 0 immediately (asynchronous), and relock needs 4 fresh samples.
- Inject 300 errors with ERR_CNT_WIDTH=8 → err_count_out saturates at 255. Then clear_in together with an error → err_count_out=1, fail_out=1. Then clear_in alone → both 0.
